// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: frame states,
// scan-code set 2 values, HID keycodes and the scan-code to keycode map.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } frame_state_e;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [7:0] KC_NONE  = 8'h00;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_SPACE = 8'h2C;
    localparam logic [7:0] KC_ENTER = 8'h28;
    localparam logic [7:0] KC_UP    = 8'h52;
    localparam logic [7:0] KC_DOWN  = 8'h51;
    localparam logic [7:0] KC_LEFT  = 8'h50;
    localparam logic [7:0] KC_RIGHT = 8'h4F;

    // Returns KC_NONE for any code outside the supported key set.
    function automatic logic [7:0] map_scan_code(input logic [7:0] code, input logic ext);
        logic [7:0] kc;
        kc = KC_NONE;
        if (ext) begin
            case (code)
                SC_UP:    kc = KC_UP;
                SC_DOWN:  kc = KC_DOWN;
                SC_LEFT:  kc = KC_LEFT;
                SC_RIGHT: kc = KC_RIGHT;
                default:  kc = KC_NONE;
            endcase
        end else begin
            case (code)
                SC_A:     kc = KC_A;
                SC_D:     kc = KC_D;
                SC_S:     kc = KC_S;
                SC_W:     kc = KC_W;
                SC_SPACE: kc = KC_SPACE;
                SC_ENTER: kc = KC_ENTER;
                default:  kc = KC_NONE;
            endcase
        end
        return kc;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises and filters the raw lines, deserialises
// 11-bit frames and reports the byte or a parity/framing/timeout error.
module ps2_frame_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_strobe,
    output logic       o_parity_err,
    output logic       o_frame_err
);
    import ps2_pkg::*;

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    r_clk_sync, r_dat_sync;
    logic          r_filt, r_filt_prev;
    logic [FW-1:0] r_filt_cnt;
    frame_state_e  r_state, w_state_d;
    logic [7:0]    r_shift, w_shift_d;
    logic [2:0]    r_bit_cnt, w_bit_cnt_d;
    logic          r_parity, w_parity_d;
    logic [TW-1:0] r_tmo, w_tmo_d;
    logic [7:0]    r_rx_byte, w_rx_byte_d;
    logic          r_strobe, w_strobe_d;
    logic          r_perr, w_perr_d;
    logic          r_ferr, w_ferr_d;
    logic          w_sample, w_data;

    assign w_sample = r_filt_prev & ~r_filt;
    assign w_data   = r_dat_sync[1];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_clk_sync  <= 2'b11;
            r_dat_sync  <= 2'b11;
            r_filt      <= 1'b1;
            r_filt_prev <= 1'b1;
            r_filt_cnt  <= '0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync  <= {r_dat_sync[0], i_ps2_data};
            r_filt_prev <= r_filt;
            // Filtered level only follows after FILTER_LEN consecutive differing cycles.
            if (r_clk_sync[1] == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FILT_MAX) begin
                r_filt     <= r_clk_sync[1];
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_shift_d   = r_shift;
        w_bit_cnt_d = r_bit_cnt;
        w_parity_d  = r_parity;
        w_rx_byte_d = r_rx_byte;
        w_strobe_d  = 1'b0;
        w_perr_d    = 1'b0;
        w_ferr_d    = 1'b0;
        w_tmo_d     = (r_state == StIdle || w_sample) ? '0 : r_tmo + 1'b1;
        unique case (r_state)
            StIdle: if (w_sample) begin
                if (!w_data) begin
                    w_state_d   = StData;
                    w_bit_cnt_d = '0;
                end else begin
                    w_ferr_d = 1'b1;
                end
            end
            StData: if (w_sample) begin
                w_shift_d   = {w_data, r_shift[7:1]};
                w_bit_cnt_d = r_bit_cnt + 1'b1;
                if (r_bit_cnt == 3'd7) w_state_d = StParity;
            end
            StParity: if (w_sample) begin
                w_parity_d = w_data;
                w_state_d  = StStop;
            end
            StStop: if (w_sample) begin
                w_state_d = StIdle;
                if (!w_data) begin
                    w_ferr_d = 1'b1;
                end else if (^{r_shift, r_parity}) begin
                    w_rx_byte_d = r_shift;
                    w_strobe_d  = 1'b1;
                end else begin
                    w_perr_d = 1'b1;
                end
            end
        endcase
        // A sample in the same cycle takes precedence over the timeout.
        if (r_state != StIdle && !w_sample && r_tmo == TMO_MAX) begin
            w_state_d = StIdle;
            w_ferr_d  = 1'b1;
            w_tmo_d   = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_tmo     <= '0;
            r_rx_byte <= '0;
            r_strobe  <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_shift   <= w_shift_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_parity  <= w_parity_d;
            r_tmo     <= w_tmo_d;
            r_rx_byte <= w_rx_byte_d;
            r_strobe  <= w_strobe_d;
            r_perr    <= w_perr_d;
            r_ferr    <= w_ferr_d;
        end
    end

    assign o_rx_byte    = r_rx_byte;
    assign o_rx_strobe  = r_strobe;
    assign o_parity_err = r_perr;
    assign o_frame_err  = r_ferr;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard to HID keycode translator: tracks F0/E0 prefixes and holds the current key.
// Define PS2_EXT_KEYS_EN to enable the E0-prefixed arrow keys.
module ps2_keycode_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_keycode,
    output logic       o_key_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_strobe,
    output logic       o_parity_err,
    output logic       o_frame_err
);
    import ps2_pkg::*;

    logic [7:0] w_rx_byte, w_mapped;
    logic       w_rx_strobe, w_ext_ok;
    logic       r_brk, w_brk_d;
    logic       r_ext, w_ext_d;
    logic [7:0] r_keycode, w_keycode_d;
    logic       r_key_valid, w_key_valid_d;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_ps2_clk   (i_ps2_clk),
        .i_ps2_data  (i_ps2_data),
        .o_rx_byte   (w_rx_byte),
        .o_rx_strobe (w_rx_strobe),
        .o_parity_err(o_parity_err),
        .o_frame_err (o_frame_err)
    );

    assign w_mapped = map_scan_code(w_rx_byte, r_ext);

`ifdef PS2_EXT_KEYS_EN
    assign w_ext_ok = 1'b1;
`else
    assign w_ext_ok = ~r_ext;
`endif

    always_comb begin
        w_brk_d     = r_brk;
        w_ext_d     = r_ext;
        w_keycode_d = r_keycode;
        if (w_rx_strobe) begin
            if (w_rx_byte == SC_BREAK) begin
                w_brk_d = 1'b1;
            end else if (w_rx_byte == SC_EXT) begin
                w_ext_d = 1'b1;
            end else begin
                if (w_mapped != KC_NONE && w_ext_ok) begin
                    if (!r_brk) begin
                        w_keycode_d = w_mapped;
                    end else if (w_mapped == r_keycode) begin
                        w_keycode_d = KC_NONE;
                    end
                end
                w_brk_d = 1'b0;
                w_ext_d = 1'b0;
            end
        end
        // Typematic repeats rewrite the same value and must not pulse.
        w_key_valid_d = (w_keycode_d != r_keycode);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_brk       <= 1'b0;
            r_ext       <= 1'b0;
            r_keycode   <= KC_NONE;
            r_key_valid <= 1'b0;
        end else begin
            r_brk       <= w_brk_d;
            r_ext       <= w_ext_d;
            r_keycode   <= w_keycode_d;
            r_key_valid <= w_key_valid_d;
        end
    end

    assign o_keycode   = r_keycode;
    assign o_key_valid = r_key_valid;
    assign o_rx_byte   = w_rx_byte;
    assign o_rx_strobe = w_rx_strobe;

endmodule
